// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_ctrl_pkg
//   Shared definitions for the sequential shift-add multiplier family:
//   default operand/product widths, the implementation select flag,
//   the controller FSM state type and the iteration-counter width helper.
package mul_seq_ctrl_pkg;

  localparam int unsigned DEF_X_WIDTH  = 3;
  localparam int unsigned DEF_Y_WIDTH  = 3;
  localparam int unsigned DEF_P_WIDTH  = DEF_X_WIDTH + DEF_Y_WIDTH;

  // Selects the sequential multiplier in place of the combinational cores.
  localparam bit          IMPL_MUL_SEQ = 1'b1;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_ITER = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  // Counter must index 0..n-1; keep at least one bit for n == 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_step.sv
// mul_step
//   One combinational shift-add iteration: when ybit_i is set the
//   multiplicand magnitude, shifted left by the iteration index, is added
//   to the accumulator. Kept separate so the adder can be reused and
//   inspected at gate level on its own.
//   Ports:
//     acc_i   [P_WIDTH-1:0] current accumulator
//     xmag_i  [X_WIDTH-1:0] multiplicand magnitude
//     ybit_i                current multiplier bit
//     count_i [CNT_W-1:0]   iteration index (shift amount)
//     acc_o   [P_WIDTH-1:0] next accumulator
module mul_step
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned X_WIDTH = DEF_X_WIDTH,
  parameter int unsigned P_WIDTH = DEF_P_WIDTH,
  parameter int unsigned CNT_W   = cnt_width(DEF_Y_WIDTH)
) (
  input  logic [P_WIDTH-1:0] acc_i,
  input  logic [X_WIDTH-1:0] xmag_i,
  input  logic               ybit_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic [P_WIDTH-1:0] acc_o
);

  logic [P_WIDTH-1:0] xext;

  always_comb begin
    xext                = '0;
    xext[X_WIDTH-1:0]   = xmag_i;
    acc_o               = acc_i;
    if (ybit_i) begin
      acc_o = acc_i + (xext << count_i);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequential shift-add multiplier controller. Captures an operand pair
//   on start, converts signed operands to magnitudes plus a sign flag,
//   then performs one partial-product step per clock. The registered
//   product magnitude and sign are presented once all Y_WIDTH steps are
//   done and held until the next accepted start.
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous reset, active low
//     start request a multiply (ignored while iterating)
//     sgn   1: x/y are two's complement, 0: unsigned
//     x     [X_WIDTH-1:0] multiplicand
//     y     [Y_WIDTH-1:0] multiplier
//     p     [P_WIDTH-1:0] registered product magnitude
//     s     registered product sign (1 = negative)
//     busy  iterating
//     rdy   p/s hold a completed result
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned X_WIDTH = DEF_X_WIDTH,
  parameter int unsigned Y_WIDTH = DEF_Y_WIDTH,
  parameter int unsigned P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] p,
  output logic               s,
  output logic               busy,
  output logic               rdy
);

  localparam int unsigned CNT_W = cnt_width(Y_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Y_WIDTH - 1);

  mc_state_e          state_q, state_d;
  logic [P_WIDTH-1:0] acc_q,   acc_d;
  logic [X_WIDTH-1:0] xmag_q,  xmag_d;
  logic [Y_WIDTH-1:0] ymag_q,  ymag_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               neg_q,   neg_d;
  logic [P_WIDTH-1:0] p_q,     p_d;
  logic               s_q,     s_d;

  logic [P_WIDTH-1:0] acc_step;

  mul_step #(
    .X_WIDTH (X_WIDTH),
    .P_WIDTH (P_WIDTH),
    .CNT_W   (CNT_W)
  ) u_step (
    .acc_i   (acc_q),
    .xmag_i  (xmag_q),
    .ybit_i  (ymag_q[0]),
    .count_i (cnt_q),
    .acc_o   (acc_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MC_IDLE;
      acc_q   <= '0;
      xmag_q  <= '0;
      ymag_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xmag_q  <= xmag_d;
      ymag_q  <= ymag_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    xmag_d  = xmag_q;
    ymag_d  = ymag_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    s_d     = s_q;

    unique case (state_q)
      MC_IDLE, MC_DONE: begin
        if (start) begin
          state_d = MC_ITER;
          acc_d   = '0;
          cnt_d   = '0;
          if (sgn) begin
            // Two's-complement negate in operand width: the most negative
            // value maps onto its unsigned magnitude (e.g. 100 -> 4).
            xmag_d = x[X_WIDTH-1] ? (~x + X_WIDTH'(1)) : x;
            ymag_d = y[Y_WIDTH-1] ? (~y + Y_WIDTH'(1)) : y;
            neg_d  = x[X_WIDTH-1] ^ y[Y_WIDTH-1];
          end else begin
            xmag_d = x;
            ymag_d = y;
            neg_d  = 1'b0;
          end
        end
      end
      MC_ITER: begin
        acc_d  = acc_step;
        ymag_d = ymag_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = MC_DONE;
          p_d     = acc_step;
          // A zero product is reported as non-negative.
          s_d     = neg_q & (acc_step != '0);
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  assign p    = p_q;
  assign s    = s_q;
  assign busy = (state_q == MC_ITER);
  assign rdy  = (state_q == MC_DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  localparam int unsigned X_W = 3;
  localparam int unsigned Y_W = 3;
  localparam int unsigned P_W = X_W + Y_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           sgn = 1'b0;
  logic [X_W-1:0] x = '0;
  logic [Y_W-1:0] y = '0;
  logic [P_W-1:0] p;
  logic           s, busy, rdy;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  mul_seq_ctrl #(
    .X_WIDTH (X_W),
    .Y_WIDTH (Y_W),
    .P_WIDTH (P_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .x     (x),
    .y     (y),
    .p     (p),
    .s     (s),
    .busy  (busy),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as integers and multiply.
  function automatic void model(input logic sg, input logic [X_W-1:0] xx,
                                input logic [Y_W-1:0] yy,
                                output logic [P_W-1:0] ep, output logic es);
    int xv, yv, pr;
    xv = int'(xx);
    yv = int'(yy);
    if (sg && xx[X_W-1]) xv = xv - (1 << X_W);
    if (sg && yy[Y_W-1]) yv = yv - (1 << Y_W);
    pr = xv * yv;
    es = (pr < 0);
    ep = P_W'(pr < 0 ? -pr : pr);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for exactly one edge; returns just after it.
  task automatic drive_start(input logic sg, input logic [X_W-1:0] xx,
                             input logic [Y_W-1:0] yy);
    sgn = sg; x = xx; y = yy; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({p, s, busy, rdy} !== '0) begin
      $display("FAIL reset_vals: got p=%0d s=%0b busy=%0b rdy=%0b want all 0", p, s, busy, rdy);
    end else n_pass++;
    #9 rst = 1'b1;
    tick();
    n_total++;
    if ({p, s, busy, rdy} !== '0) begin
      $display("FAIL reset_idle: got p=%0d s=%0b busy=%0b rdy=%0b want all 0", p, s, busy, rdy);
    end else n_pass++;
  endtask

  task automatic test_unsigned();
    int bcnt;
    drive_start(1'b0, 3'd7, 3'd7);
    bcnt = busy ? 1 : 0;
    n_total++;
    if (rdy !== 1'b0) $display("FAIL u77_rdy_low: got %0b want 0", rdy);
    else n_pass++;
    for (int i = 0; i < Y_W; i++) begin
      tick();
      if (busy) bcnt++;
    end
    n_total++;
    if ({rdy, p, s} !== {1'b1, 6'd49, 1'b0})
      $display("FAIL u77_result: got rdy=%0b p=%0d s=%0b want rdy=1 p=49 s=0", rdy, p, s);
    else n_pass++;
    n_total++;
    if (bcnt != Y_W) $display("FAIL u77_busy_len: got %0d want %0d", bcnt, Y_W);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [X_W-1:0] xs [3] = '{3'b100, 3'b100, 3'b000};
    logic [Y_W-1:0] ys [3] = '{3'b011, 3'b100, 3'b101};
    logic [P_W-1:0] ep [3] = '{6'd12, 6'd16, 6'd0};
    logic           es [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive_start(1'b1, xs[k], ys[k]);
      repeat (Y_W) tick();
      n_total++;
      if ({rdy, p, s} !== {1'b1, ep[k], es[k]})
        $display("FAIL signed_%0d: got rdy=%0b p=%0d s=%0b want rdy=1 p=%0d s=%0b",
                 k, rdy, p, s, ep[k], es[k]);
      else n_pass++;
    end
    // DONE holds the result with no new start.
    repeat (3) tick();
    n_total++;
    if ({rdy, busy, p, s} !== {1'b1, 1'b0, 6'd0, 1'b0})
      $display("FAIL done_hold: got rdy=%0b busy=%0b p=%0d s=%0b", rdy, busy, p, s);
    else n_pass++;
    drive_start(1'b0, 3'd0, 3'd7);
    repeat (Y_W) tick();
    n_total++;
    if ({rdy, p, s} !== {1'b1, 6'd0, 1'b0})
      $display("FAIL u07: got rdy=%0b p=%0d s=%0b want rdy=1 p=0 s=0", rdy, p, s);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    logic [P_W-1:0] prev_p;
    logic           prev_s;
    // Establish a nonzero previous result first.
    drive_start(1'b1, 3'b100, 3'b011);
    repeat (Y_W) tick();
    prev_p = 6'd12;
    prev_s = 1'b1;
    drive_start(1'b0, 3'd2, 3'd3);
    sgn = 1'b0; x = 3'd5; y = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({busy, rdy, p, s} !== {1'b1, 1'b0, prev_p, prev_s})
      $display("FAIL iter_hold1: got busy=%0b rdy=%0b p=%0d s=%0b want 1 0 %0d %0b",
               busy, rdy, p, s, prev_p, prev_s);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, rdy, p, s} !== {1'b1, 1'b0, prev_p, prev_s})
      $display("FAIL iter_hold2: got busy=%0b rdy=%0b p=%0d s=%0b want 1 0 %0d %0b",
               busy, rdy, p, s, prev_p, prev_s);
    else n_pass++;
    tick();
    n_total++;
    if ({rdy, p, s} !== {1'b1, 6'd6, 1'b0})
      $display("FAIL ignore_start: got rdy=%0b p=%0d s=%0b want rdy=1 p=6 s=0", rdy, p, s);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    sgn = 1'b0; x = 3'd3; y = 3'd2; start = 1'b1;
    tick();                                   // edge k: accept 3x2
    tick();                                   // edge k+1
    x = 3'd1; y = 3'd1;
    tick();                                   // edge k+2
    tick();                                   // edge k+3
    n_total++;
    if ({rdy, p} !== {1'b1, 6'd6})
      $display("FAIL b2b_first: got rdy=%0b p=%0d want rdy=1 p=6", rdy, p);
    else n_pass++;
    tick();                                   // edge k+4: accept 1x1
    n_total++;
    if ({rdy, busy, p} !== {1'b0, 1'b1, 6'd6})
      $display("FAIL b2b_restart: got rdy=%0b busy=%0b p=%0d want 0 1 6", rdy, busy, p);
    else n_pass++;
    repeat (Y_W) tick();                      // edge k+7
    start = 1'b0;
    n_total++;
    if ({rdy, p, s} !== {1'b1, 6'd1, 1'b0})
      $display("FAIL b2b_second: got rdy=%0b p=%0d s=%0b want rdy=1 p=1 s=0", rdy, p, s);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive_start(1'b1, 3'b111, 3'b011);        // -1 x 3, previous p=1 still shown
    tick();
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({p, s, busy, rdy} !== '0)
      $display("FAIL async_rst: got p=%0d s=%0b busy=%0b rdy=%0b want all 0", p, s, busy, rdy);
    else n_pass++;
    #2 rst = 1'b1;
    tick();
    n_total++;
    if ({p, busy, rdy} !== '0)
      $display("FAIL post_rst_idle: got p=%0d busy=%0b rdy=%0b want all 0", p, busy, rdy);
    else n_pass++;
    drive_start(1'b0, 3'd2, 3'd2);
    repeat (Y_W) tick();
    n_total++;
    if ({rdy, p, s} !== {1'b1, 6'd4, 1'b0})
      $display("FAIL post_rst_2x2: got rdy=%0b p=%0d s=%0b want rdy=1 p=4 s=0", rdy, p, s);
    else n_pass++;
  endtask

  task automatic test_random();
    logic           sg;
    logic [X_W-1:0] xx;
    logic [Y_W-1:0] yy;
    logic [P_W-1:0] ep;
    logic           es;
    int             lat;
    for (int k = 0; k < 40; k++) begin
      sg = 1'($urandom_range(0, 1));
      xx = X_W'($urandom);
      yy = Y_W'($urandom);
      model(sg, xx, yy, ep, es);
      drive_start(sg, xx, yy);
      lat = 1;
      while (!rdy && lat < 12) begin
        tick();
        lat++;
      end
      n_total++;
      if (lat != Y_W + 1 || {rdy, p, s} !== {1'b1, ep, es})
        $display("FAIL rand_%0d: sgn=%0b x=%0d y=%0d got lat=%0d rdy=%0b p=%0d s=%0b want lat=%0d p=%0d s=%0b",
                 k, sg, xx, yy, lat, rdy, p, s, Y_W + 1, ep, es);
      else n_pass++;
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential shift-add multiplier controller for the small-multiplier family. It captures an X×Y operand pair on `start`, then sequences one partial-product step per clock through a single adder/shift datapath. It presents a registered product with a sign flag and a ready level on the same pins as the combinational multipliers. It is instantiated directly under the top wrapper in place of the combinational `x3y3` cores, and is selectable from config.

## Interface
Parameters:
- `X_WIDTH`, default 3: multiplicand width.
- `Y_WIDTH`, default 3: multiplier width; also the number of iterations.
- `P_WIDTH`, default `X_WIDTH+Y_WIDTH`: product magnitude width.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `start`, input, 1: request a multiply; sampled on the rising edge.
- `sgn`, input, 1: 1 means `x` and `y` are two's complement; 0 means unsigned. Sampled with `start`.
- `x`, input, `X_WIDTH`: multiplicand.
- `y`, input, `Y_WIDTH`: multiplier.
- `p`, output, `P_WIDTH`: product magnitude, registered.
- `s`, output, 1: product sign, registered; 1 means negative.
- `busy`, output, 1: high while iterating.
- `rdy`, output, 1: high while `p`/`s` hold a completed result.

## Operation
- FSM states: IDLE, ITER, DONE. Encoding is binary, 2 bits.
- Start acceptance:
  - In IDLE or DONE with `start`=1: capture operands and go to ITER.
  - On capture: clear the accumulator, set iteration count to 0, set `rdy`=0.
- Operand capture:
  - If `sgn`=1: store `|x|`, `|y|` as unsigned magnitudes and latch `neg = x[MSB]^y[MSB]`.
  - If `sgn`=0: `neg`=0.
  - The most negative value converts correctly, e.g. −4 becomes magnitude 4 in 3 bits unsigned.
- Each ITER cycle:
  - If `ymag[0]`=1: `acc += xmag << count`.
  - Then `ymag >>= 1` and `count++`.
  - Accumulator is `P_WIDTH` bits and cannot overflow.
- Completion: after the iteration with `count == Y_WIDTH-1`, go to DONE.
  - Load `p <= acc_final`.
  - Load `s <= neg & (acc_final != 0)`. A zero product is never negative.
- DONE holds `p`, `s`, `rdy`=1 indefinitely until the next accepted `start`.
- `start` in ITER is ignored: no queueing, no restart.
- `p`/`s` update only on entry to DONE; they keep the previous result during ITER.
- `busy` = (state == ITER). `rdy` = (state == DONE). Both come from registered state.
- Reset values: state IDLE, `p`=0, `s`=0, `busy`=0, `rdy`=0, accumulator/count/operand registers 0.
- Reset asserted mid-ITER aborts the operation. After release the block is in IDLE; the partial result is never presented.

## Timing
- Edge k samples `start`=1 in IDLE/DONE. After edge k: `busy`=1, `rdy`=0.
- Edges k+1 … k+`Y_WIDTH` perform the `Y_WIDTH` iterations.
- After edge k+`Y_WIDTH`: `busy`=0, `rdy`=1, `p`/`s` valid. Latency is `Y_WIDTH`+1 edges (4 at default).
- Back-to-back: `start` held high in DONE is accepted on the next edge. Throughput is one result per `Y_WIDTH`+1 cycles.
- Reset release: first accepted `start` is on the first rising edge after `rst` goes high.
- No combinational path from any input to any output.

## Structure
- Shared header `mul_ctrl.vh`:
  - FSM state encodings `MC_IDLE`/`MC_ITER`/`MC_DONE`.
  - Iteration counter width `$clog2(Y_WIDTH)`.
  - Default widths come from `config.vh` (`X_WIDTH`, `Y_WIDTH`, `P_WIDTH`), plus new `IMPL_MUL_SEQ` select define.
- One sub-module, `mul_step`: combinational single iteration.
  - Inputs: acc, xmag, ybit, count.
  - Output: next acc.
  - Keeps the adder isolated for reuse and gate-level inspection.
- Controller holds the FSM, operand/magnitude registers, counter and output registers.

## Test plan
- Unsigned 7×7 (`sgn`=0): `start` pulse → after 4 edges `rdy`=1, `p`=49, `s`=0; `busy` high for exactly 3 cycles.
- Signed −4×3 (`x`=3'b100, `y`=3'b011, `sgn`=1) → `p`=12, `s`=1. Signed −4×−4 → `p`=16, `s`=0.
- Signed 0×−3 → `p`=0, `s`=0 (zero never negative). Unsigned 0×7 → `p`=0.
- `start` re-pulsed with new operands (5×5) during ITER of 2×3 → ignored; result `p`=6. Previous `p` is held unchanged throughout ITER.
- `start` held high continuously (3×2 then 1×1 on the bus) → results 6 then 1, each `rdy` for one cycle, period 4 cycles.
- `rst`=0 asserted mid-ITER (asynchronous, between edges) → outputs 0 immediately. After release: IDLE, `rdy`=0, next 2×2 gives `p`=4.
